// File: rtl/fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc, instruction} FIFO between fetch and decode,
// valid/ready on both sides, single-cycle flush on taken branch.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instruction,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_instruction,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_pc_mem  [DEPTH];
  logic [WIDTH-1:0] r_ins_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  // Full/empty come only from the occupancy register, so in_ready has no path from out_ready.
  assign in_ready  = (r_count != CW'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  assign out_pc          = out_valid ? r_pc_mem[r_rd_ptr]  : '0;
  assign out_instruction = out_valid ? r_ins_mem[r_rd_ptr] : '0;
  assign count           = r_count;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push) begin
      r_pc_mem[r_wr_ptr]  <= in_pc;
      r_ins_mem[r_wr_ptr] <= in_instruction;
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch queue between the fetch stage and decode. Buffers up to DEPTH fetched {pc, instruction} pairs so fetch can keep advancing while decode stalls. A valid/ready handshake applies on both sides. A branch flush discards all buffered entries in one cycle.

## Interface

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2
- WIDTH, 32, width of pc and instruction fields

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-low (state clears on a rising clk edge while rst==0)
- flush  input  1  branch taken; discards all entries
- in_valid  input  1  fetch presents an entry
- in_pc  input  WIDTH  pc of the presented instruction
- in_instruction  input  WIDTH  presented instruction word
- in_ready  output  1  queue can accept an entry this cycle
- out_valid  output  1  head entry is available to decode
- out_pc  output  WIDTH  pc of the head entry
- out_instruction  output  WIDTH  instruction of the head entry
- out_ready  input  1  decode consumes the head this cycle (deasserted on freeze)
- count  output  $clog2(DEPTH)+1  current occupancy

## Operation

- State:
  - storage array of DEPTH {pc, instruction} entries
  - wr_ptr and rd_ptr, each $clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
- Handshakes:
  - push = in_valid && in_ready
  - pop = out_valid && out_ready
- Outputs:
  - in_ready = (count != DEPTH), driven from registered count only; no combinational path from out_ready.
  - out_valid = (count != 0).
  - out_pc and out_instruction = storage[rd_ptr] when out_valid, otherwise 0.
  - count output = the count register.
- Per-edge priority, highest first:
  1. rst==0: wr_ptr, rd_ptr and count go to 0. Storage contents are don't-care, but outputs still read 0 because out_valid==0.
  2. flush==1: wr_ptr, rd_ptr and count go to 0. A same-cycle push or pop is discarded.
  3. Otherwise:
     - push: write storage[wr_ptr], then wr_ptr+1.
     - pop: rd_ptr+1.
     - count += push - pop.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - This is legal at any occupancy 1..DEPTH-1.
  - When full, push cannot occur because in_ready==0.
  - When empty, pop cannot occur because out_valid==0, so there is no bypass.
- Wrap-around: pointers roll from DEPTH-1 to 0. Full and empty are distinguished only by count, never by pointer equality.
- Behaviour when in_valid==0 or out_ready==0: the queue holds and the outputs stay stable.
- Out-of-protocol input is ignored, with no state change:
  - in_valid while in_ready==0
  - out_ready while out_valid==0

## Timing

- Reset values:
  - in_ready=1, out_valid=0, out_pc=0, out_instruction=0, count=0.
- Latency:
  - An entry pushed at edge N is visible on the out_* ports after edge N.
  - Minimum entry-to-exit latency is one cycle.
- Throughput: one push and one pop per cycle sustained when 0<count<DEPTH.
- Flush timing:
  - A flush asserted at edge N gives out_valid=0 and in_ready=1 after edge N.
  - Fetch may push the branch-target entry at edge N+1.
- Reset mid-operation: identical to flush, and takes priority over flush.
- Critical paths:
  - in_ready and out_valid are decodes of a register.
  - out_* is a DEPTH:1 mux on rd_ptr.

## Test plan

- Reset then fill:
  - Stimulus: rst=0 for 2 cycles, then push pc=0x00,0x04,0x08,0x0C with instructions 0xE0000000+pc, out_ready=0.
  - Response: count goes 1,2,3,4; in_ready=0 after the 4th push; out_pc=0x00 throughout.
  - A 5th in_valid with pc=0x10 is ignored and count stays 4.
- Drain:
  - Stimulus: from full, out_ready=1 and in_valid=0.
  - Response: out_pc sequence is 0x00,0x04,0x08,0x0C, one per cycle; then out_valid=0, out_pc=0, count=0.
- Streaming with wrap:
  - Stimulus: in_valid=1 and out_ready=1 every cycle for 12 cycles, pc incrementing by 4 from 0x100.
  - Response: after a 1-cycle fill, count stays 1; out_pc lags in_pc by exactly one cycle; pointers wrap 3 times with no loss or duplication.
- Freeze:
  - Stimulus: while streaming, hold out_ready=0 for 5 cycles with in_valid=1.
  - Response: count climbs to 4 and holds; in_ready=0; out_pc stays frozen at the stalled head.
  - On release, entries exit in order.
- Flush with simultaneous push and pop:
  - Stimulus: count=3, then in one cycle assert flush=1, in_valid=1 with pc=0x200, out_ready=1.
  - Response: next cycle count=0, out_valid=0, in_ready=1.
  - Pushing pc=0x300 the following cycle gives out_pc=0x300.
- Reset mid-operation:
  - Stimulus: count=2, then rst=0 together with flush=1 and in_valid=1.
  - Response: after the edge all outputs are at reset values; the first push after rst=1 appears at out_pc.
